// File: rtl/cbus_arbiter.sv
// cbus_arbiter: arbitrates NUM_PORTS cbus masters onto one cbus, one whole transaction at a time.
// Build option CBUS_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority with port 0 highest.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [63:0] data;
      logic [7:0]  strobe;
   } cbus_req_t;
   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic       aclk,
   input  logic       areset,
   input  cbus_req_t  ireqs  [NUM_PORTS],
   output cbus_resp_t iresps [NUM_PORTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);
   localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nxt;
   logic [SW-1:0] sel, sel_nxt, winner;
   logic any_valid, done;
   assign done = (state == BUSY) && oresp.ready && oresp.last;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
   logic [SW-1:0] last_sel, idx;
   always_ff @(posedge aclk)
      if (!areset) last_sel <= SW'(NUM_PORTS - 1);
      else if (done) last_sel <= sel;
   // scan farthest-first so the nearest valid port after last_sel wins
   always_comb begin
      winner = '0;
      any_valid = 1'b0;
      idx = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = SW'((int'(last_sel) + k) % NUM_PORTS);
         if (ireqs[idx].valid) begin
            winner = idx;
            any_valid = 1'b1;
         end
      end
   end
`else
   always_comb begin
      winner = '0;
      any_valid = 1'b0;
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (ireqs[i].valid) begin
            winner = SW'(i);
            any_valid = 1'b1;
         end
   end
`endif
   always_ff @(posedge aclk)
      if (!areset) begin
         state <= IDLE;
         sel <= '0;
      end else begin
         state <= state_nxt;
         sel <= sel_nxt;
      end
   always_comb begin
      state_nxt = state;
      sel_nxt = sel;
      oreq = '0;
      for (int j = 0; j < NUM_PORTS; j++) iresps[j] = '0;
      if (state == IDLE) begin
         if (any_valid) begin
            state_nxt = BUSY;
            sel_nxt = winner;
         end
      end else begin
         oreq = ireqs[sel];
         iresps[sel] = oresp;
         if (done) state_nxt = IDLE;
      end
   end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed scenarios plus randomized masters/bridge checked every cycle
// against a transaction-level owner model.
module tb_cbus_arbiter;
   import cbus_pkg::*;
   localparam int N = 2;
   logic aclk = 1'b0;
   logic areset = 1'b0;
   cbus_req_t  ireqs  [N];
   cbus_resp_t iresps [N];
   cbus_req_t  oreq;
   cbus_resp_t oresp;
   int checks = 0, errors = 0;
   int owner = -1, rr = N - 1, bcnt = 0;
   bit done_seen [N];
   bit m_active [N];

   always #5 aclk = ~aclk;

   cbus_arbiter #(.NUM_PORTS(N)) dut (
      .aclk(aclk), .areset(areset), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
   );

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic cbus_req_t mk(logic we, logic [31:0] a, logic [7:0] l, logic [63:0] d, logic [7:0] s);
      mk = '{valid: 1'b1, we: we, addr: a, len: l, data: d, strobe: s};
   endfunction

   function automatic int pick();
      for (int k = 1; k <= N; k++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
         int p = (rr + k) % N;
`else
         int p = k - 1;
`endif
         if (ireqs[p].valid) return p;
      end
      return -1;
   endfunction

   // advance the model across one clock edge using the inputs held at that edge
   task automatic step();
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) done_seen[i] = 1'b0;
      if (!areset) begin
         owner = -1;
         rr = N - 1;
         bcnt = 0;
      end else if (owner < 0) owner = pick();
      else if (oresp.ready) begin
         if (oresp.last) begin
            done_seen[owner] = 1'b1;
            rr = owner;
            owner = -1;
            bcnt = 0;
         end else bcnt++;
      end
   endtask

   task automatic chk();
      logic [127:0] e;
      #1;
      e = '0;
      if (owner >= 0) e = ireqs[owner];
      cmp("oreq", oreq, e);
      for (int i = 0; i < N; i++) begin
         e = '0;
         if (i == owner) e = oresp;
         cmp($sformatf("iresps%0d", i), iresps[i], e);
      end
   endtask

   initial begin
      logic [63:0] d [4];
      logic [31:0] a [2];
      int p;
      d = '{64'h11, 64'h22, 64'h33, 64'h44};
      oresp = '0;
      ireqs[0] = mk(1'b0, 32'h1000_0000, 8'd0, 64'h0, 8'h0);
      ireqs[1] = mk(1'b0, 32'h8000_0040, 8'd3, 64'h0, 8'h0);
      repeat (3) begin
         step(); chk();
         cmp("rst_valid", oreq.valid, 1'b0);
         cmp("rst_iresp0", iresps[0], 66'h0);
      end
      areset = 1'b1;
      chk(); cmp("release_idle", oreq.valid, 1'b0);
      step(); chk();
      cmp("grant0_valid", oreq.valid, 1'b1);
      cmp("grant0_addr", oreq.addr, 32'h1000_0000);
      oresp = '{ready: 1'b1, last: 1'b1, data: 64'h55};
      chk(); cmp("t1_last0", iresps[0].last, 1'b1);
      step(); ireqs[0].valid = 1'b0; oresp = '0;
      chk(); cmp("t1_bubble", oreq.valid, 1'b0);
      step(); chk();
      cmp("t2_addr", oreq.addr, 32'h8000_0040);
      cmp("t2_len", oreq.len, 8'd3);
      for (int b = 0; b < 4; b++) begin
         oresp = '{ready: 1'b1, last: (b == 3), data: d[b]};
         chk();
         cmp("t2_beat_data", iresps[1].data, d[b]);
         cmp("t2_port0_quiet", iresps[0], 66'h0);
         step();
      end
      ireqs[1].valid = 1'b0; oresp = '0;
      chk(); cmp("t2_after_last", oreq.valid, 1'b0);
      a = '{32'h2000_0000, 32'h3000_0000};
      ireqs[0] = mk(1'b0, a[0], 8'd0, 64'h0, 8'h0);
      ireqs[1] = mk(1'b0, a[1], 8'd0, 64'h0, 8'h0);
      chk();
      for (int g = 0; g < 4; g++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
         p = g % 2;
`else
         p = 0;
`endif
         step(); chk();
         cmp("t3_grant_addr", oreq.addr, a[p]);
         oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
         chk();
         step(); oresp = '0;
         a[p] = a[p] + 32'h100;
         ireqs[p].addr = a[p];
         if (g == 3) begin
            ireqs[0].valid = 1'b0;
            ireqs[1].valid = 1'b0;
         end
         chk(); cmp("t3_bubble", oreq.valid, 1'b0);
      end
      ireqs[0] = mk(1'b1, 32'h5000_0000, 8'd1, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      chk();
      step(); chk();
      cmp("t5_data1", oreq.data, 64'hDEAD_BEEF_0000_0001);
      cmp("t5_strobe", oreq.strobe, 8'hFF);
      step(); oresp = '{ready: 1'b1, last: 1'b0, data: 64'h0};
      chk(); cmp("t5_ready1", iresps[0].ready, 1'b1);
      step(); oresp = '0; ireqs[0].data = 64'hDEAD_BEEF_0000_0002;
      chk(); cmp("t5_data2", oreq.data, 64'hDEAD_BEEF_0000_0002);
      step(); oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
      chk(); cmp("t5_last", iresps[0].last, 1'b1);
      step(); ireqs[0].valid = 1'b0; oresp = '0;
      chk(); cmp("t5_end", oreq.valid, 1'b0);
      ireqs[1] = mk(1'b0, 32'h4000_0000, 8'd3, 64'h0, 8'h0);
      chk();
      step();
      oresp = '{ready: 1'b1, last: 1'b0, data: 64'h77};
      chk(); step(); chk(); step();
      areset = 1'b0; oresp = '0;
      chk(); cmp("t6_busy_at_rst", oreq.valid, 1'b1);
      step(); areset = 1'b1;
      chk(); cmp("t6_rst_valid", oreq.valid, 1'b0);
      step(); chk();
      cmp("t6_regrant", oreq.addr, 32'h4000_0000);
      areset = 1'b0;
      for (int i = 0; i < N; i++) begin
         ireqs[i] = '0;
         m_active[i] = 1'b0;
      end
      step(); areset = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         step();
         for (int i = 0; i < N; i++)
            if (done_seen[i]) begin
               m_active[i] = 1'b0;
               ireqs[i].valid = 1'b0;
            end else if (!m_active[i] && $urandom_range(0, 3) == 0) begin
               ireqs[i] = mk(1'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 3)),
                             {$urandom, $urandom}, 8'($urandom));
               m_active[i] = 1'b1;
            end
         areset = ($urandom_range(0, 99) != 0);
         oresp.ready = ($urandom_range(0, 2) != 0);
         oresp.data = {$urandom, $urandom};
         oresp.last = (owner >= 0) ? (oresp.ready && bcnt == int'(ireqs[owner].len))
                                   : 1'($urandom_range(0, 1));
         chk();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
